tlp_tx_arbiter: RTL and testbench
=================================

# tlp_tx_arbiter

Packet-atomic round-robin arbiter sharing the single PCIe TX stream (64-bit data, SOP/EOP, valid/ready) between `NUM_SRC` TLP sources, e.g. the completion/DMA-write generator and a future MSI/message generator. It sits between those sources and the PCIe core TX port. It never interleaves beats of different TLPs. It reports the current grant and any framing violations.

## Interface
- `NUM_SRC`, 2: number of requesting TLP sources; must be ≥2.
- `SRC_BITS`, `$clog2(NUM_SRC)`: width of grant index (derived; do not override).

- `pcieClk_in`  in  1  125MHz core clock; all logic on rising edge.
- `pcieResetN_in`  in  1  reset, synchronous, active-low.
- `srcData_in[NUM_SRC]`  in  64 each  per-source TLP beat.
- `srcValid_in`  in  NUM_SRC  per-source beat valid.
- `srcReady_out`  out  NUM_SRC  per-source beat accepted (valid&ready = transfer).
- `srcSOP_in`  in  NUM_SRC  first beat of TLP.
- `srcEOP_in`  in  NUM_SRC  last beat of TLP.
- `txData_out`  out  64  to PCIe core.
- `txValid_out`  out  1  to PCIe core.
- `txReady_in`  in  1  from PCIe core.
- `txSOP_out`  out  1  to PCIe core.
- `txEOP_out`  out  1  to PCIe core.
- `busy_out`  out  1  a packet is in flight.
- `grant_out`  out  SRC_BITS  index of granted/last-granted source.
- `protoErr_out`  out  1  sticky: a non-granted source offered a beat without SOP.

## Operation
- Registered state: `state` ∈ {IDLE, BUSY}, `grant` (SRC_BITS), `lastGrant` (SRC_BITS), `protoErr`.
- Request: source i requests iff `srcValid_in[i] & srcSOP_in[i]`.
- IDLE: if any request, `grant` ← first requesting index scanning `lastGrant+1, lastGrant+2, …` modulo NUM_SRC (wrap from NUM_SRC-1 to 0). Next state is BUSY. With no request, stay in IDLE.
- BUSY: combinational mux of source `grant` to tx outputs. `txValid_out = srcValid_in[grant]`. `srcReady_out[grant] = txReady_in`. All other `srcReady_out` bits are 0 except when draining a bad beat (below).
- BUSY exit: on `txValid_out & txReady_in & txEOP_out`, next state is IDLE and `lastGrant` ← `grant`.
- A beat with SOP=EOP=1 is a one-beat packet and completes in one transfer.
- SOP asserted mid-packet by the granted source is forwarded unchanged; the arbiter does not check it.
- Framing violation: in IDLE, a source with `srcValid_in & ~srcSOP_in` is not a requester. Its `srcReady_out` is asserted for that cycle to drop the beat, and `protoErr` ← 1. `protoErr` clears only on reset.
- Sources are not required to hold valid; a granted source may insert bubbles mid-packet. `txValid_out` follows the source, and the grant holds until EOP.
- Outputs when not BUSY:
  - `txValid_out`=0, `txSOP_out`=0, `txEOP_out`=0.
  - `txData_out` = `srcData_in[grant]`, which is don't-care for the PCIe core.
- Fairness: with all sources continuously requesting, grants rotate 0,1,…,NUM_SRC-1,0. No source waits more than NUM_SRC-1 packets.

## Timing
- Reset (`pcieResetN_in`=0 at an edge) sets:
  - state=IDLE, grant=0, lastGrant=NUM_SRC-1 (source 0 wins first);
  - protoErr=0, busy_out=0, grant_out=0;
  - txValid_out=0, srcReady_out=0.
- Reset mid-packet abandons the packet immediately. No EOP is synthesised; the PCIe core is reset together with this block.
- Arbitration latency: a request visible in cycle N → first beat on `txValid_out` in cycle N+1. This is one bubble per packet.
- Back-to-back packets: after the EOP transfer in cycle M, the arbiter is in IDLE in cycle M+1. The next packet's first beat appears at M+2 at the earliest. Sustained efficiency is L/(L+1) for L-beat packets.
- `busy_out` = (state==BUSY). `grant_out` = `grant` register. Both update one cycle after the decision edge.
- Data/SOP/EOP/valid have zero latency source→tx while BUSY. Ready has zero latency tx→source.
- Backpressure: `txReady_in`=0 stalls the granted source only; arbitration state is frozen.
- Simultaneous requests in IDLE: round-robin order applies; the losers see `srcReady_out`=0 and must hold their beats.

## Test plan
- Single source: src0 sends a 3-beat TLP (data 0x11,0x22,0x33, SOP on beat 0, EOP on beat 2), txReady=1. Required: tx carries the same 3 beats starting 1 cycle after src0 valid; grant_out=0; busy_out returns to 0 the cycle after EOP.
- Contention: src0 and src1 both request continuously with 2-beat TLPs after reset. Required: grant order 0,1,0,1; no beat interleaving; one idle cycle between packets.
- Backpressure: txReady_in toggles 1,0,0,1,… during a 4-beat packet from src1. Required: srcReady_out[1] mirrors txReady_in; all 4 beats delivered in order, exactly once; src0's request is not granted until after EOP.
- One-beat packet (SOP=EOP=1, data 0xDEADBEEF) from src1, then src0 requests. Required: src1's beat is transferred in one cycle, then src0 is granted 2 cycles after the EOP transfer.
- Framing error: src1 offers valid, SOP=0 while in IDLE. Required: srcReady_out[1]=1 for that cycle, the beat is not forwarded, and protoErr_out=1 stays high through later traffic until reset.
- Reset mid-packet: assert pcieResetN_in=0 during beat 2 of a 4-beat src0 packet. Required: next cycle txValid_out=0, busy_out=0, grant_out=0, protoErr_out=0; after release, src0 and src1 both requesting → src0 is granted first.

Source files
------------

// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: packet-atomic round-robin arbiter that shares one 64-bit
// PCIe TX stream between NUM_SRC TLP sources. A grant is taken only on a
// SOP beat and is held until the EOP beat has transferred, so beats of
// different TLPs never interleave. Beats offered without SOP while idle are
// drained and flagged in a sticky protocol-error bit.
module tlp_tx_arbiter #(
  parameter int NUM_SRC  = 2,
  parameter int SRC_BITS = $clog2(NUM_SRC)
) (
  input  logic                pcieClk_in,
  input  logic                pcieResetN_in,
  input  logic [63:0]         srcData_in [NUM_SRC],
  input  logic [NUM_SRC-1:0]  srcValid_in,
  output logic [NUM_SRC-1:0]  srcReady_out,
  input  logic [NUM_SRC-1:0]  srcSOP_in,
  input  logic [NUM_SRC-1:0]  srcEOP_in,
  output logic [63:0]         txData_out,
  output logic                txValid_out,
  input  logic                txReady_in,
  output logic                txSOP_out,
  output logic                txEOP_out,
  output logic                busy_out,
  output logic [SRC_BITS-1:0] grant_out,
  output logic                protoErr_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbState_e;

  arbState_e           stateReg, stateNext;
  logic [SRC_BITS-1:0] grantReg, grantNext;
  logic [SRC_BITS-1:0] lastGrantReg, lastGrantNext;
  logic                protoErrReg, protoErrNext;

  logic [NUM_SRC-1:0]  requestVec;
  logic [NUM_SRC-1:0]  dropVec;
  logic                pickValid;
  logic [SRC_BITS-1:0] pickIdx;
  logic [SRC_BITS-1:0] scanIdx;

  // Per-source request/drain decode and ready steering. While a packet is in
  // flight only the owner sees the core's ready; while idle, a beat without
  // SOP is acknowledged so the offending source can move past it. The drain
  // is held off during reset so nothing is consumed before the core is up.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
      assign requestVec[gi] = srcValid_in[gi] & srcSOP_in[gi];
      assign dropVec[gi]    = (stateReg == IDLE) & srcValid_in[gi] &
                              ~srcSOP_in[gi] & pcieResetN_in;
      assign srcReady_out[gi] = ((stateReg == BUSY) && (grantReg == SRC_BITS'(gi)))
                                ? txReady_in : dropVec[gi];
    end
  endgenerate

  // Round-robin pick: scan lastGrant+NUM_SRC down to lastGrant+1 so the
  // requester closest after the previous winner is the one left standing.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    scanIdx   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      scanIdx = SRC_BITS'((int'(lastGrantReg) + k) % NUM_SRC);
      if (requestVec[scanIdx]) begin
        pickValid = 1'b1;
        pickIdx   = scanIdx;
      end
    end
  end

  // Next-state and TX mux: idle arbitrates, busy forwards the owner's beats
  // with zero latency and releases the grant on the EOP transfer.
  always_comb begin
    stateNext     = stateReg;
    grantNext     = grantReg;
    lastGrantNext = lastGrantReg;
    protoErrNext  = protoErrReg | (|dropVec);
    txValid_out   = 1'b0;
    txSOP_out     = 1'b0;
    txEOP_out     = 1'b0;
    txData_out    = srcData_in[grantReg];
    case (stateReg)
      IDLE: begin
        if (pickValid) begin
          stateNext = BUSY;
          grantNext = pickIdx;
        end
      end
      BUSY: begin
        txValid_out = srcValid_in[grantReg];
        txSOP_out   = srcSOP_in[grantReg];
        txEOP_out   = srcEOP_in[grantReg];
        if (srcValid_in[grantReg] & txReady_in & srcEOP_in[grantReg]) begin
          stateNext     = IDLE;
          lastGrantNext = grantReg;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State registers; lastGrant resets to the top index so source 0 wins first.
  always_ff @(posedge pcieClk_in) begin
    if (!pcieResetN_in) begin
      stateReg     <= IDLE;
      grantReg     <= '0;
      lastGrantReg <= SRC_BITS'(NUM_SRC - 1);
      protoErrReg  <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      grantReg     <= grantNext;
      lastGrantReg <= lastGrantNext;
      protoErrReg  <= protoErrNext;
    end
  end

  assign busy_out     = (stateReg == BUSY);
  assign grant_out    = grantReg;
  assign protoErr_out = protoErrReg;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Testbench for tlp_tx_arbiter: per-source beat queues drive the DUT, and a
// packet-level reference model (owner / last owner / sticky error) predicts
// every output each cycle. Directed scenarios run first, then random traffic
// with bubbles and backpressure.
module tb_tlp_tx_arbiter;

  localparam int N  = 2;
  localparam int SB = $clog2(N);

  logic          clk = 1'b0;
  logic          rstN;
  logic [63:0]   srcData [N];
  logic [N-1:0]  srcValid, srcSOP, srcEOP, srcReady;
  logic [63:0]   txData;
  logic          txValid, txReady, txSOP, txEOP, busy, protoErr;
  logic [SB-1:0] grant;

  tlp_tx_arbiter #(.NUM_SRC(N)) dut (
    .pcieClk_in   (clk),
    .pcieResetN_in(rstN),
    .srcData_in   (srcData),
    .srcValid_in  (srcValid),
    .srcReady_out (srcReady),
    .srcSOP_in    (srcSOP),
    .srcEOP_in    (srcEOP),
    .txData_out   (txData),
    .txValid_out  (txValid),
    .txReady_in   (txReady),
    .txSOP_out    (txSOP),
    .txEOP_out    (txEOP),
    .busy_out     (busy),
    .grant_out    (grant),
    .protoErr_out (protoErr)
  );

  initial forever #5 clk = ~clk;

  // Source programs: each entry is {sop, eop, data}.
  logic [65:0]   srcQ [N][$];
  logic [SB-1:0] grantObs [$];
  bit            bubbleOn = 1'b0;
  int            readyMode = 0;     // 0: random with readyPct, 1: 1,0,0,1 pattern
  int            readyPct  = 100;
  int            cycCnt = 0;
  int            delivered = 0;
  int            pushed = 0;
  int            compared = 0;
  int            mismatched = 0;
  bit            checkEn = 1'b0;

  // Reference model state.
  bit            mBusy = 1'b0;
  logic [SB-1:0] mOwner = '0;
  logic [SB-1:0] mLast = SB'(N - 1);
  bit            mErr = 1'b0;
  logic [N-1:0]  expReadyV;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushBeat(input int s, input bit sop, input bit eop, input logic [63:0] d);
    srcQ[s].push_back({sop, eop, d});
    pushed++;
  endtask

  task automatic pushPkt(input int s, input int len);
    for (int b = 0; b < len; b++)
      pushBeat(s, b == 0, b == len - 1, {$urandom, $urandom});
  endtask

  task automatic drive();
    logic [65:0] h;
    for (int s = 0; s < N; s++) begin
      if (srcQ[s].size() > 0 && (!bubbleOn || $urandom_range(3) != 0)) begin
        h = srcQ[s][0];
        srcValid[s] = 1'b1;
        srcSOP[s]   = h[65];
        srcEOP[s]   = h[64];
        srcData[s]  = h[63:0];
      end else begin
        srcValid[s] = 1'b0;
        srcSOP[s]   = 1'($urandom);
        srcEOP[s]   = 1'($urandom);
        srcData[s]  = {$urandom, $urandom};
      end
    end
    if (readyMode == 1) txReady = (cycCnt % 4 == 0) || (cycCnt % 4 == 3);
    else                txReady = ($urandom_range(99) < readyPct);
  endtask

  // Apply the edge to the model using the inputs that were held across it.
  task automatic commit();
    logic [SB-1:0] s;
    if (!rstN) begin
      mBusy = 1'b0; mOwner = '0; mLast = SB'(N - 1); mErr = 1'b0;
      for (int i = 0; i < N; i++) srcQ[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (srcValid[i] & expReadyV[i]) begin
          if (mBusy) delivered++;
          else mErr = 1'b1;
          void'(srcQ[i].pop_front());
        end
      end
      if (mBusy) begin
        if (srcValid[mOwner] & txReady & srcEOP[mOwner]) begin
          mBusy = 1'b0;
          mLast = mOwner;
        end
      end else begin
        for (int d = 1; d <= N; d++) begin
          s = SB'((int'(mLast) + d) % N);
          if (srcValid[s] & srcSOP[s]) begin
            mBusy  = 1'b1;
            mOwner = s;
            grantObs.push_back(grant);
            break;
          end
        end
      end
    end
  endtask

  // One clock: drive after the edge, compare mid-cycle, update model after the edge.
  task automatic step();
    logic [N-1:0] er;
    drive();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      er[i] = mBusy ? ((SB'(i) == mOwner) ? txReady : 1'b0)
                    : (srcValid[i] & ~srcSOP[i] & rstN);
    expReadyV = er;
    if (checkEn) begin
      check("txValid",  txValid,  mBusy ? srcValid[mOwner] : 1'b0);
      check("txSOP",    txSOP,    mBusy ? srcSOP[mOwner]   : 1'b0);
      check("txEOP",    txEOP,    mBusy ? srcEOP[mOwner]   : 1'b0);
      check("txData",   txData,   srcData[mOwner]);
      check("srcReady", srcReady, er);
      check("busy",     busy,     mBusy);
      check("grant",    grant,    mOwner);
      check("protoErr", protoErr, mErr);
    end
    @(posedge clk);
    #1;
    commit();
    cycCnt++;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = !mBusy;
      for (int i = 0; i < N; i++) if (srcQ[i].size() != 0) done = 1'b0;
    end
    check("drain_done", done, 1'b1);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
  endtask

  initial begin
    int expBeats;
    txReady = 1'b1;
    srcValid = '0; srcSOP = '0; srcEOP = '0;
    for (int i = 0; i < N; i++) srcData[i] = '0;

    // Reset: first edge brings registers out of X, second cycle is checked.
    rstN = 1'b0;
    step();
    checkEn = 1'b1;
    step();
    rstN = 1'b1;
    $display("reset: busy=%0b grant=%0d protoErr=%0b", busy, grant, protoErr);

    // Single source, 3-beat TLP.
    delivered = 0;
    pushBeat(0, 1'b1, 1'b0, 64'h11);
    pushBeat(0, 1'b0, 1'b0, 64'h22);
    pushBeat(0, 1'b0, 1'b1, 64'h33);
    drain(20);
    check("single_beats", delivered, 3);
    $display("single: delivered=%0d", delivered);

    // Contention after reset: 2-beat TLPs from both, order must be 0,1,0,1.
    doReset();
    grantObs.delete();
    for (int p = 0; p < 2; p++) begin
      pushPkt(0, 2);
      pushPkt(1, 2);
    end
    drain(40);
    check("contention_count", grantObs.size(), 4);
    for (int k = 0; k < 4 && k < grantObs.size(); k++) begin
      check("contention_order", grantObs[k], k % 2);
      $display("contention: grant[%0d]=%0d", k, grantObs[k]);
    end

    // Backpressure on a 4-beat src1 packet while src0 waits.
    readyMode = 1;
    grantObs.delete();
    pushPkt(1, 4);
    step();
    pushPkt(0, 2);
    drain(60);
    readyMode = 0;
    check("bp_first", grantObs.size() > 0 ? grantObs[0] : SB'(0), 1);
    check("bp_second", grantObs.size() > 1 ? grantObs[1] : SB'(1), 0);
    $display("backpressure: grants=%0d", grantObs.size());

    // One-beat packet from src1, then src0.
    grantObs.delete();
    pushBeat(1, 1'b1, 1'b1, 64'hDEADBEEF);
    step();
    pushPkt(0, 2);
    drain(20);
    check("onebeat_order", grantObs.size() > 1 ? grantObs[1] : SB'(1), 0);
    $display("one-beat: grants=%0d", grantObs.size());

    // Framing violation from src1 while idle, then normal traffic.
    pushBeat(1, 1'b0, 1'b0, 64'hBAD0BAD0);
    step();
    pushPkt(0, 3);
    pushPkt(1, 2);
    drain(40);
    check("protoErr_sticky", protoErr, 1'b1);
    $display("framing: protoErr=%0b", protoErr);

    // Random traffic with bubbles and backpressure.
    bubbleOn = 1'b1;
    readyPct = 70;
    delivered = 0;
    pushed = 0;
    for (int p = 0; p < 12; p++)
      for (int s = 0; s < N; s++) pushPkt(s, $urandom_range(4, 1));
    expBeats = pushed;
    drain(3000);
    check("random_beats", delivered, expBeats);
    $display("random: delivered=%0d pushed=%0d", delivered, expBeats);
    bubbleOn = 1'b0;
    readyPct = 100;

    // Reset during beat 2 of a 4-beat src0 packet.
    pushPkt(0, 4);
    step();
    step();
    step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 0);
    check("rst_protoErr", protoErr, 1'b0);
    grantObs.delete();
    pushPkt(0, 2);
    pushPkt(1, 2);
    drain(30);
    check("rst_first_grant", grantObs.size() > 0 ? grantObs[0] : SB'(1), 0);
    $display("reset-mid-packet: first grant=%0d", grantObs.size() > 0 ? grantObs[0] : SB'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
